// File: rtl/id_issue_pkg.sv
// Shared decode constants for the ID/issue stage: opcode and funct fields,
// ALU operation and result-class encodings, reset level and zero word.
package id_issue_pkg;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;

    // SPECIAL funct codes (inst[5:0])
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    typedef enum logic [7:0] {
        ALUOP_NOP   = 8'b0000_0000,
        ALUOP_ADDU  = 8'b0010_0001,
        ALUOP_SUBU  = 8'b0010_0011,
        ALUOP_AND   = 8'b0010_0100,
        ALUOP_OR    = 8'b0010_0101,
        ALUOP_XOR   = 8'b0010_0110,
        ALUOP_NOR   = 8'b0010_0111,
        ALUOP_ADDIU = 8'b0101_0110,
        ALUOP_SLL   = 8'b0111_1100,
        ALUOP_LW    = 8'b1110_0011
    } aluop_e;

    typedef enum logic [2:0] {
        ALUSEL_NOP   = 3'b000,
        ALUSEL_LOGIC = 3'b001,
        ALUSEL_SHIFT = 3'b010,
        ALUSEL_ARITH = 3'b100,
        ALUSEL_LDST  = 3'b111
    } alusel_e;

endpackage

// File: rtl/id_fwd_mux.sv
// Operand resolver for one source: r0, forwarding network (youngest wins),
// regfile fallback, or the immediate when the source is not read.
module id_fwd_mux
    import id_issue_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 5,
    parameter int FWD_STAGES = 2
) (
    input  logic                         re,
    input  logic [RADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]            rf_data,
    input  logic [DATA_W-1:0]            imm,
    input  logic [FWD_STAGES-1:0]        fwd_wreg,
    input  logic [FWD_STAGES*RADDR_W-1:0] fwd_wd,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_wdata,
    input  logic [FWD_STAGES-1:0]        fwd_pending,
    output logic [DATA_W-1:0]            data,
    output logic                         pending
);

    // Scan oldest to youngest so the lowest-index match overwrites older ones;
    // the winner's pending flag travels with it, so an older ready match
    // can never hide a younger load still in flight.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data    = rf_data;
        pending = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (fwd_wreg[k] && (fwd_wd[k*RADDR_W +: RADDR_W] == addr)) begin
                data    = fwd_wdata[k*DATA_W +: DATA_W];
                pending = fwd_pending[k];
            end
        end
        if (!re) begin
            data    = imm;
            pending = 1'b0;
        end else if (addr == '0) begin
            data    = '0;
            pending = 1'b0;
        end
    end

endmodule

// File: rtl/id_issue.sv
// ID/issue stage: decodes a MIPS32 integer subset, resolves operands through
// the forwarding network, stalls on load-use, and registers the bundle into
// a valid/ready slot toward EX.
// Optional: define ID_STALL_CNT_EN to add stall_cnt_o, a saturating count of
// cycles with a valid instruction held back by a load-use hazard.
module id_issue
    import id_issue_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 5,
    parameter int FWD_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [31:0]                   pc_i,
    input  logic [31:0]                   inst_i,
    input  logic                          flush_i,
    output logic [RADDR_W-1:0]            reg1_addr_o,
    output logic [RADDR_W-1:0]            reg2_addr_o,
    input  logic [DATA_W-1:0]             reg1_data_i,
    input  logic [DATA_W-1:0]             reg2_data_i,
    input  logic [FWD_STAGES-1:0]         fwd_wreg_i,
    input  logic [FWD_STAGES*RADDR_W-1:0] fwd_wd_i,
    input  logic [FWD_STAGES*DATA_W-1:0]  fwd_wdata_i,
    input  logic [FWD_STAGES-1:0]         fwd_pending_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [7:0]                    aluop_o,
    output logic [2:0]                    alusel_o,
    output logic [DATA_W-1:0]             reg1_o,
    output logic [DATA_W-1:0]             reg2_o,
    output logic [RADDR_W-1:0]            wd_o,
    output logic                          wreg_o,
    output logic                          is_load_o,
    output logic [31:0]                   pc_o,
    output logic                          inst_invalid_o
`ifdef ID_STALL_CNT_EN
   ,output logic [31:0]                   stall_cnt_o
`endif
);

    logic [5:0]         op, funct;
    logic [RADDR_W-1:0] rs, rt, rd;
    logic [15:0]        imm;

    aluop_e             dec_aluop;
    alusel_e            dec_alusel;
    logic               dec_re1, dec_re2, dec_wreg, dec_load, dec_invalid;
    logic [RADDR_W-1:0] dec_wd;
    logic [DATA_W-1:0]  dec_imm1, dec_imm2;

    logic [DATA_W-1:0]  op1, op2;
    logic               pend1, pend2, hazard, slot_free, issue;

    assign op    = inst_i[31:26];
    assign funct = inst_i[5:0];
    assign rs    = RADDR_W'(inst_i[25:21]);
    assign rt    = RADDR_W'(inst_i[20:16]);
    assign rd    = RADDR_W'(inst_i[15:11]);
    assign imm   = inst_i[15:0];

    // Instruction decode: read enables, immediates, destination, ALU control.
    always_comb begin
        dec_aluop   = ALUOP_NOP;
        dec_alusel  = ALUSEL_NOP;
        dec_re1     = 1'b0;
        dec_re2     = 1'b0;
        dec_wreg    = 1'b0;
        dec_load    = 1'b0;
        dec_invalid = 1'b0;
        dec_wd      = rd;
        dec_imm1    = '0;
        dec_imm2    = '0;
        case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec_aluop  = (op == OP_ORI) ? ALUOP_OR : (op == OP_ANDI) ? ALUOP_AND : ALUOP_XOR;
                dec_alusel = ALUSEL_LOGIC;
                dec_re1    = 1'b1;
                dec_wreg   = 1'b1;
                dec_wd     = rt;
                dec_imm2   = DATA_W'(imm);
            end
            OP_ADDIU: begin
                dec_aluop  = ALUOP_ADDIU;
                dec_alusel = ALUSEL_ARITH;
                dec_re1    = 1'b1;
                dec_wreg   = 1'b1;
                dec_wd     = rt;
                dec_imm2   = DATA_W'($signed(imm));
            end
            OP_LUI: begin
                dec_aluop  = ALUOP_OR;
                dec_alusel = ALUSEL_LOGIC;
                dec_wreg   = 1'b1;
                dec_wd     = rt;
                dec_imm2   = DATA_W'({imm, 16'h0000});
            end
            OP_LW: begin
                dec_aluop  = ALUOP_LW;
                dec_alusel = ALUSEL_LDST;
                dec_re1    = 1'b1;
                dec_wreg   = 1'b1;
                dec_load   = 1'b1;
                dec_wd     = rt;
                dec_imm2   = DATA_W'($signed(imm));
            end
            OP_SPECIAL: begin
                dec_alusel = ALUSEL_LOGIC;
                dec_re1    = 1'b1;
                dec_re2    = 1'b1;
                dec_wreg   = 1'b1;
                case (funct)
                    FN_OR:   dec_aluop = ALUOP_OR;
                    FN_AND:  dec_aluop = ALUOP_AND;
                    FN_XOR:  dec_aluop = ALUOP_XOR;
                    FN_NOR:  dec_aluop = ALUOP_NOR;
                    FN_ADDU: begin dec_aluop = ALUOP_ADDU; dec_alusel = ALUSEL_ARITH; end
                    FN_SUBU: begin dec_aluop = ALUOP_SUBU; dec_alusel = ALUSEL_ARITH; end
                    FN_SLL: begin
                        dec_aluop  = ALUOP_SLL;
                        dec_alusel = ALUSEL_SHIFT;
                        dec_re1    = 1'b0;
                        dec_imm1   = DATA_W'(inst_i[10:6]);
                    end
                    default: begin
                        dec_alusel  = ALUSEL_NOP;
                        dec_re1     = 1'b0;
                        dec_re2     = 1'b0;
                        dec_wreg    = 1'b0;
                        dec_invalid = 1'b1;
                    end
                endcase
            end
            default: dec_invalid = 1'b1;
        endcase
    end

    id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .FWD_STAGES(FWD_STAGES)) u_mux1 (
        .re(dec_re1), .addr(rs), .rf_data(reg1_data_i), .imm(dec_imm1),
        .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i),
        .fwd_pending(fwd_pending_i), .data(op1), .pending(pend1)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .FWD_STAGES(FWD_STAGES)) u_mux2 (
        .re(dec_re2), .addr(rt), .rf_data(reg2_data_i), .imm(dec_imm2),
        .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i),
        .fwd_pending(fwd_pending_i), .data(op2), .pending(pend2)
    );

    assign reg1_addr_o = (rst == RST_ENABLE) ? '0 : rs;
    assign reg2_addr_o = (rst == RST_ENABLE) ? '0 : rt;

    assign hazard     = pend1 | pend2;
    assign slot_free  = !out_valid_o || out_ready_i;
    assign in_ready_o = slot_free && !hazard && !flush_i;
    assign issue      = in_valid_i && in_ready_o;

    // Output slot: flush kills, issue loads, accept drains, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            out_valid_o    <= 1'b0;
            aluop_o        <= ALUOP_NOP;
            alusel_o       <= ALUSEL_NOP;
            reg1_o         <= '0;
            reg2_o         <= '0;
            wd_o           <= '0;
            wreg_o         <= 1'b0;
            is_load_o      <= 1'b0;
            pc_o           <= ZERO_WORD;
            inst_invalid_o <= 1'b0;
        end else if (flush_i) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            out_valid_o <= 1'b0;
        end else if (issue) begin
            out_valid_o    <= 1'b1;
            aluop_o        <= dec_aluop;
            alusel_o       <= dec_alusel;
            reg1_o         <= op1;
            reg2_o         <= op2;
            wd_o           <= dec_wd;
            wreg_o         <= dec_wreg;
            is_load_o      <= dec_load;
            pc_o           <= pc_i;
            inst_invalid_o <= dec_invalid;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

`ifdef ID_STALL_CNT_EN
    // Saturating count of cycles a valid instruction waits on a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            stall_cnt_o <= ZERO_WORD;
        end else if (in_valid_i && hazard && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_issue.sv
// Directed self-checking bench for id_issue (default parameters).
module tb_id_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i, in_ready_o, flush_i;
    logic [31:0] pc_i, inst_i;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic [1:0]  fwd_wreg_i, fwd_pending_i;
    logic [9:0]  fwd_wd_i;
    logic [63:0] fwd_wdata_i;
    logic        out_valid_o, out_ready_i;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] reg1_o, reg2_o, pc_o;
    logic [4:0]  wd_o;
    logic        wreg_o, is_load_o, inst_invalid_o;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] cnt_before;
`endif

    int checks = 0;
    int errors = 0;

    id_issue dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
        .fwd_pending_i(fwd_pending_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .is_load_o(is_load_o), .pc_o(pc_o),
        .inst_invalid_o(inst_invalid_o)
`ifdef ID_STALL_CNT_EN
       ,.stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs_f,
                                          input logic [4:0] rt_f, input logic [15:0] imm_f);
        return {op, rs_f, rt_f, imm_f};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                          input logic [4:0] rd_f, input logic [4:0] sa_f,
                                          input logic [5:0] fn_f);
        return {6'b000000, rs_f, rt_f, rd_f, sa_f, fn_f};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_fwd();
        fwd_wreg_i    = 2'b00;
        fwd_pending_i = 2'b00;
        fwd_wd_i      = '0;
        fwd_wdata_i   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        pc_i = 32'h0; inst_i = itype(6'h0D, 5'd1, 5'd2, 16'h0);
        reg1_data_i = 32'h0; reg2_data_i = 32'h0; no_fwd();
        tick(); tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", out_valid_o); end
        checks++; if ({aluop_o, alusel_o, wreg_o, is_load_o, inst_invalid_o} !== 14'h0) begin errors++; $display("FAIL reset_ctrl got %h/%h/%b%b%b exp 0", aluop_o, alusel_o, wreg_o, is_load_o, inst_invalid_o); end
        checks++; if ({reg1_o, reg2_o, wd_o, pc_o} !== 101'h0) begin errors++; $display("FAIL reset_data got %h %h %h %h exp 0", reg1_o, reg2_o, wd_o, pc_o); end
        checks++; if ({reg1_addr_o, reg2_addr_o} !== 10'h0) begin errors++; $display("FAIL reset_addr got %h %h exp 0", reg1_addr_o, reg2_addr_o); end
`ifdef ID_STALL_CNT_EN
        checks++; if (stall_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", stall_cnt_o); end
`endif
        rst = 1'b0;
        #1;
        checks++; if ({reg1_addr_o, reg2_addr_o} !== {5'd1, 5'd2}) begin errors++; $display("FAIL addr_after_reset got %h %h exp 01 02", reg1_addr_o, reg2_addr_o); end
    endtask

    task automatic test_decode();
        // ORI r2,r1,0x00FF
        in_valid_i = 1'b1; pc_i = 32'h0000_0100; inst_i = itype(6'h0D, 5'd1, 5'd2, 16'h00FF);
        reg1_data_i = 32'h1234_0000; reg2_data_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL ori_ready got %b exp 1", in_ready_o); end
        tick();
        checks++; if ({out_valid_o, aluop_o, alusel_o} !== {1'b1, 8'h25, 3'd1}) begin errors++; $display("FAIL ori_ctrl got %b %h %h exp 1 25 1", out_valid_o, aluop_o, alusel_o); end
        checks++; if ({reg1_o, reg2_o} !== {32'h1234_0000, 32'h0000_00FF}) begin errors++; $display("FAIL ori_ops got %h %h exp 12340000 000000ff", reg1_o, reg2_o); end
        checks++; if ({wd_o, wreg_o, is_load_o, inst_invalid_o, pc_o} !== {5'd2, 3'b100, 32'h100}) begin errors++; $display("FAIL ori_wd got %h %b%b%b %h exp 02 100 00000100", wd_o, wreg_o, is_load_o, inst_invalid_o, pc_o); end
        // SLL r7,r3,5: reg1 = sa, reg2 = rt from regfile
        inst_i = rtype(5'd0, 5'd3, 5'd7, 5'd5, 6'h00); reg2_data_i = 32'h0000_0003;
        tick();
        checks++; if ({aluop_o, alusel_o, reg1_o, reg2_o, wd_o} !== {8'h7C, 3'd2, 32'd5, 32'd3, 5'd7}) begin errors++; $display("FAIL sll got %h %h %h %h %h exp 7c 2 5 3 7", aluop_o, alusel_o, reg1_o, reg2_o, wd_o); end
        // LUI r9,0xABCD
        inst_i = itype(6'h0F, 5'd4, 5'd9, 16'hABCD); reg1_data_i = 32'h5555_5555;
        tick();
        checks++; if ({reg1_o, reg2_o, wd_o, wreg_o} !== {32'h0, 32'hABCD_0000, 5'd9, 1'b1}) begin errors++; $display("FAIL lui got %h %h %h %b exp 0 abcd0000 9 1", reg1_o, reg2_o, wd_o, wreg_o); end
        // LW r8,-4(r9)
        inst_i = itype(6'h23, 5'd9, 5'd8, 16'hFFFC); reg1_data_i = 32'h0000_1000;
        tick();
        checks++; if ({aluop_o, alusel_o, is_load_o, reg1_o, reg2_o, wd_o} !== {8'hE3, 3'd7, 1'b1, 32'h1000, 32'hFFFF_FFFC, 5'd8}) begin errors++; $display("FAIL lw got %h %h %b %h %h %h exp e3 7 1 1000 fffffffc 8", aluop_o, alusel_o, is_load_o, reg1_o, reg2_o, wd_o); end
    endtask

    task automatic test_fwd_priority();
        // ADDU r3,r1,r2: stage0 and stage1 both write r1, youngest wins
        inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
        reg1_data_i = 32'h1111_1111; reg2_data_i = 32'h0000_0005;
        fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'h0000_BBBB, 32'h0000_AAAA};
        tick();
        checks++; if ({aluop_o, alusel_o, reg1_o, reg2_o} !== {8'h21, 3'd4, 32'h0000_AAAA, 32'h5}) begin errors++; $display("FAIL fwd_young got %h %h %h %h exp 21 4 aaaa 5", aluop_o, alusel_o, reg1_o, reg2_o); end
        // stage1 alone supplies r2; r1 comes from the regfile
        fwd_wreg_i = 2'b10; fwd_wd_i = {5'd2, 5'd1}; fwd_wdata_i = {32'h0000_0005, 32'h0000_AAAA};
        reg2_data_i = 32'hDEAD_DEAD;
        tick();
        checks++; if ({reg1_o, reg2_o} !== {32'h1111_1111, 32'h5}) begin errors++; $display("FAIL fwd_old got %h %h exp 11111111 5", reg1_o, reg2_o); end
        no_fwd();
    endtask

    task automatic test_load_use();
        // ADDU r6,r4,r0 while a load to r4 is still in EX
        inst_i = rtype(5'd4, 5'd0, 5'd6, 5'd0, 6'h21); reg1_data_i = 32'h0000_0001;
        fwd_wreg_i = 2'b11; fwd_pending_i = 2'b01; fwd_wd_i = {5'd4, 5'd4};
        fwd_wdata_i = {32'h0000_0033, 32'h0};
`ifdef ID_STALL_CNT_EN
        cnt_before = stall_cnt_o;
`endif
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL lu_ready got %b exp 0", in_ready_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b exp 0", out_valid_o); end
`ifdef ID_STALL_CNT_EN
        checks++; if (stall_cnt_o !== cnt_before + 32'd1) begin errors++; $display("FAIL lu_cnt got %h exp %h", stall_cnt_o, cnt_before + 32'd1); end
`endif
        fwd_pending_i = 2'b00; fwd_wdata_i = {32'h0000_0033, 32'h0000_0077};
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL lu_resume got %b exp 1", in_ready_o); end
        tick();
        checks++; if ({out_valid_o, reg1_o, reg2_o, wd_o} !== {1'b1, 32'h77, 32'h0, 5'd6}) begin errors++; $display("FAIL lu_issue got %b %h %h %h exp 1 77 0 6", out_valid_o, reg1_o, reg2_o, wd_o); end
        no_fwd();
    endtask

    task automatic test_r0_sext();
        // ADDIU r5,r0,0xFFFC with stage0 claiming to write r0
        inst_i = itype(6'h09, 5'd0, 5'd5, 16'hFFFC); reg1_data_i = 32'h1111_2222;
        fwd_wreg_i = 2'b01; fwd_pending_i = 2'b01; fwd_wd_i = {5'd7, 5'd0}; fwd_wdata_i = {32'h0, 32'h99};
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL r0_ready got %b exp 1", in_ready_o); end
        tick();
        checks++; if ({aluop_o, alusel_o, reg1_o, reg2_o, wd_o} !== {8'h56, 3'd4, 32'h0, 32'hFFFF_FFFC, 5'd5}) begin errors++; $display("FAIL r0_sext got %h %h %h %h %h exp 56 4 0 fffffffc 5", aluop_o, alusel_o, reg1_o, reg2_o, wd_o); end
        no_fwd();
    endtask

    task automatic test_backpressure();
        // XORI r10,r1,0xF0F0 issues, then EX stalls for three cycles
        inst_i = itype(6'h0E, 5'd1, 5'd10, 16'hF0F0); reg1_data_i = 32'h0F0F_0000; pc_i = 32'h200;
        tick();
        out_ready_i = 1'b0; inst_i = itype(6'h0D, 5'd3, 5'd11, 16'h1234); pc_i = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0", i, in_ready_o); end
            tick();
            checks++; if ({out_valid_o, aluop_o, reg1_o, reg2_o, wd_o, pc_o} !== {1'b1, 8'h26, 32'h0F0F_0000, 32'h0000_F0F0, 5'd10, 32'h200}) begin errors++; $display("FAIL bp_hold%0d got %b %h %h %h %h %h exp 1 26 0f0f0000 f0f0 a 200", i, out_valid_o, aluop_o, reg1_o, reg2_o, wd_o, pc_o); end
        end
        // flush beats a simultaneous accept and a valid instruction
        flush_i = 1'b1; out_ready_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", in_ready_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid_o); end
        flush_i = 1'b0;
        // reserved opcode 0x3F
        inst_i = {6'h3F, 26'h0ABCDEF};
        tick();
        checks++; if ({out_valid_o, inst_invalid_o, wreg_o} !== 3'b110) begin errors++; $display("FAIL invalid got %b%b%b exp 110", out_valid_o, inst_invalid_o, wreg_o); end
    endtask

    task automatic test_async_reset();
        // Put a bundle in the slot, hold it, then stall the next instruction
        inst_i = itype(6'h0D, 5'd1, 5'd2, 16'h00FF); reg1_data_i = 32'h1;
        tick();
        out_ready_i = 1'b0;
        inst_i = rtype(5'd4, 5'd0, 5'd6, 5'd0, 6'h21);
        fwd_wreg_i = 2'b01; fwd_pending_i = 2'b01; fwd_wd_i = {5'd0, 5'd4};
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({out_valid_o, aluop_o, alusel_o, wreg_o, is_load_o, inst_invalid_o} !== 15'h0) begin errors++; $display("FAIL arst_ctrl got %b %h %h %b%b%b exp 0", out_valid_o, aluop_o, alusel_o, wreg_o, is_load_o, inst_invalid_o); end
        checks++; if ({reg1_o, reg2_o, wd_o, pc_o, reg1_addr_o, reg2_addr_o} !== 111'h0) begin errors++; $display("FAIL arst_data got %h %h %h %h %h %h exp 0", reg1_o, reg2_o, wd_o, pc_o, reg1_addr_o, reg2_addr_o); end
`ifdef ID_STALL_CNT_EN
        checks++; if (stall_cnt_o !== 32'h0) begin errors++; $display("FAIL arst_cnt got %h exp 0", stall_cnt_o); end
`endif
        tick();
        rst = 1'b0; no_fwd(); in_valid_i = 1'b0; out_ready_i = 1'b1;
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL arst_after got %b exp 0", out_valid_o); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_fwd_priority();
        test_load_use();
        test_r0_sext();
        test_backpressure();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
